// File: rtl/aaa_aclk_counter.sv
// Seconds counter and HH:MM BCD time-of-day register for the alarm clock.
// Counts one_second pulses, rolls minutes/hours, and accepts validated time loads.
module aaa_aclk_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       reset_count,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] current_ms_hr,
  output logic [3:0] current_ls_hr,
  output logic [3:0] current_ms_min,
  output logic [3:0] current_ls_min,
  output logic       one_minute
);

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } hhmm_t;

  localparam logic [5:0] SEC_LAST = 6'd59;

  logic [5:0] sec_cnt;
  logic [5:0] sec_cnt_nxt;
  logic       sec_wrap;
  logic       new_valid;
  hhmm_t      cur_time;
  hhmm_t      new_time;
  hhmm_t      adv_time;
  hhmm_t      nxt_time;

  assign new_time = '{new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};

  // A load is accepted only if it is a legal 24-hour BCD time.
  assign new_valid = (new_ms_hr  <= 4'd2) &&
                     (new_ls_hr  <= 4'd9) &&
                     (new_ms_min <= 4'd5) &&
                     (new_ls_min <= 4'd9) &&
                     !((new_ms_hr == 4'd2) && (new_ls_hr > 4'd3));

  // Seconds: clear beats count; a clear also suppresses the minute advance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sec_wrap    = 1'b0;
    sec_cnt_nxt = sec_cnt;
    if (reset_count) begin
      sec_cnt_nxt = '0;
    end else if (one_second) begin
      if (sec_cnt == SEC_LAST) begin
        sec_cnt_nxt = '0;
        sec_wrap    = 1'b1;
      end else begin
        sec_cnt_nxt = sec_cnt + 6'd1;
      end
    end
  end

  // Current time plus one minute, with BCD carries through minutes and hours.
  always_comb begin
    adv_time = cur_time;
    if (cur_time.ls_min != 4'd9) begin
      adv_time.ls_min = cur_time.ls_min + 4'd1;
    end else begin
      adv_time.ls_min = 4'd0;
      if (cur_time.ms_min != 4'd5) begin
        adv_time.ms_min = cur_time.ms_min + 4'd1;
      end else begin
        adv_time.ms_min = 4'd0;
        if ((cur_time.ms_hr == 4'd2) && (cur_time.ls_hr == 4'd3)) begin
          adv_time.ms_hr = 4'd0;
          adv_time.ls_hr = 4'd0;
        end else if (cur_time.ls_hr == 4'd9) begin
          adv_time.ms_hr = cur_time.ms_hr + 4'd1;
          adv_time.ls_hr = 4'd0;
        end else begin
          adv_time.ls_hr = cur_time.ls_hr + 4'd1;
        end
      end
    end
  end

  // A load request owns the digits that edge, even when rejected as invalid.
  always_comb begin
    nxt_time = cur_time;
    if (load_new_c) begin
      if (new_valid) nxt_time = new_time;
    end else if (sec_wrap) begin
      nxt_time = adv_time;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_cnt    <= '0;
      cur_time   <= '0;
      one_minute <= 1'b0;
    end else begin
      sec_cnt    <= sec_cnt_nxt;
      cur_time   <= nxt_time;
      one_minute <= sec_wrap;
    end
  end

  assign current_ms_hr  = cur_time.ms_hr;
  assign current_ls_hr  = cur_time.ls_hr;
  assign current_ms_min = cur_time.ms_min;
  assign current_ls_min = cur_time.ls_min;

endmodule

// File: tb/tb_aaa_aclk_counter.sv
// Self-checking bench for aaa_aclk_counter: minutes-of-day reference model,
// per-cycle compare on the falling edge, and directed scenarios with literal checks.
module tb_aaa_aclk_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       reset_count = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] new_ms_hr = '0;
  logic [3:0] new_ls_hr = '0;
  logic [3:0] new_ms_min = '0;
  logic [3:0] new_ls_min = '0;
  logic [3:0] current_ms_hr;
  logic [3:0] current_ls_hr;
  logic [3:0] current_ms_min;
  logic [3:0] current_ls_min;
  logic       one_minute;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  bit chk_en   = 1'b0;

  // Reference model: seconds as an integer, time of day as minutes since midnight.
  int m_sec   = 0;
  int m_mod   = 0;
  bit m_pulse = 1'b0;

  aaa_aclk_counter dut (
    .clock          (clock),
    .reset          (reset),
    .one_second     (one_second),
    .reset_count    (reset_count),
    .load_new_c     (load_new_c),
    .new_ms_hr      (new_ms_hr),
    .new_ls_hr      (new_ls_hr),
    .new_ms_min     (new_ms_min),
    .new_ls_min     (new_ls_min),
    .current_ms_hr  (current_ms_hr),
    .current_ls_hr  (current_ls_hr),
    .current_ms_min (current_ms_min),
    .current_ls_min (current_ls_min),
    .one_minute     (one_minute)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_sec   = 0;
      m_mod   = 0;
      m_pulse = 1'b0;
    end else begin
      bit wrap;
      int hh;
      int mm;
      wrap = !reset_count && one_second && (m_sec == 59);
      if (reset_count)     m_sec = 0;
      else if (one_second) m_sec = (m_sec + 1) % 60;
      if (load_new_c) begin
        hh = 10 * int'(new_ms_hr) + int'(new_ls_hr);
        mm = 10 * int'(new_ms_min) + int'(new_ls_min);
        if (new_ms_hr <= 2 && new_ls_hr <= 9 && new_ms_min <= 5 && new_ls_min <= 9 && hh < 24)
          m_mod = hh * 60 + mm;
      end else if (wrap) begin
        m_mod = (m_mod + 1) % 1440;
      end
      m_pulse = wrap;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_ms_hr",  32'(current_ms_hr),  32'((m_mod / 60) / 10));
      check("cmp_ls_hr",  32'(current_ls_hr),  32'((m_mod / 60) % 10));
      check("cmp_ms_min", 32'(current_ms_min), 32'((m_mod % 60) / 10));
      check("cmp_ls_min", 32'(current_ls_min), 32'((m_mod % 60) % 10));
      check("cmp_one_minute", 32'(one_minute), 32'(m_pulse));
      if (one_minute) n_pulses++;
    end
  end

  // Each step applies inputs for one clock edge; tasks start and end 2 time units after a rising edge.
  task automatic step(input bit os, input bit rc, input bit ld,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    one_second  = os;
    reset_count = rc;
    load_new_c  = ld;
    new_ms_hr   = a;
    new_ls_hr   = b;
    new_ms_min  = c;
    new_ls_min  = d;
    @(posedge clock);
    #2;
    one_second  = 1'b0;
    reset_count = 1'b0;
    load_new_c  = 1'b0;
  endtask

  task automatic seconds(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    end
  endtask

  task automatic load(input bit rc, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    step(1'b0, rc, 1'b1, a, b, c, d);
  endtask

  task automatic check_time(input string name, input int hh, input int mm, input bit om);
    check({name, "_hh"}, 32'({current_ms_hr, current_ls_hr}),
          32'({4'(hh / 10), 4'(hh % 10)}));
    check({name, "_mm"}, 32'({current_ms_min, current_ls_min}),
          32'({4'(mm / 10), 4'(mm % 10)}));
    check({name, "_om"}, 32'(one_minute), 32'(om));
  endtask

  initial begin
    int p0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_time("reset_state", 0, 0, 1'b0);
    reset = 1'b1;
    chk_en = 1'b1;

    // 60 pulses from reset give exactly one minute.
    seconds(59);
    check_time("after_59", 0, 0, 1'b0);
    seconds(1);
    check_time("after_60", 0, 1, 1'b1);
    check("pulse_count_first", 32'(n_pulses), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_time("after_60_next", 0, 1, 1'b0);
    check("pulse_count_one", 32'(n_pulses), 32'd1);

    // Load with clear, then day rollover and hour-digit carries.
    load(1'b1, 4'd2, 4'd3, 4'd5, 4'd9);
    check_time("load_2359", 23, 59, 1'b0);
    seconds(60);
    check_time("roll_0000", 0, 0, 1'b1);
    load(1'b1, 4'd0, 4'd9, 4'd5, 4'd9);
    seconds(60);
    check_time("roll_1000", 10, 0, 1'b1);
    load(1'b1, 4'd1, 4'd9, 4'd5, 4'd9);
    seconds(60);
    check_time("roll_2000", 20, 0, 1'b1);

    // Invalid loads are ignored; a valid one then takes effect.
    load(1'b0, 4'd2, 4'd4, 4'd0, 4'd0);
    check_time("bad_2400", 20, 0, 1'b0);
    load(1'b0, 4'd1, 4'd2, 4'd6, 4'd0);
    check_time("bad_1260", 20, 0, 1'b0);
    load(1'b0, 4'd2, 4'hA, 4'd0, 4'd0);
    check_time("bad_2A00", 20, 0, 1'b0);
    load(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    check_time("load_1234", 12, 34, 1'b0);

    // Clear at the terminal second wins over the rollover.
    seconds(59);
    step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_time("clr_at_59", 12, 34, 1'b0);
    p0 = n_pulses;
    seconds(59);
    check_time("clr_then_59", 12, 34, 1'b0);
    check("clr_no_pulse", 32'(n_pulses), 32'(p0));
    seconds(1);
    check_time("clr_then_60", 12, 35, 1'b1);

    // Load at the terminal second: loaded value wins, pulse still fires.
    seconds(59);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 4'd1, 4'd5);
    check_time("load_at_59", 7, 15, 1'b1);
    seconds(59);
    check_time("load_then_59", 7, 15, 1'b0);
    seconds(1);
    check_time("load_then_60", 7, 16, 1'b1);

    // Asynchronous reset mid-cycle discards the partial count.
    load(1'b0, 4'd1, 4'd1, 4'd4, 4'd7);
    seconds(30);
    check_time("pre_async", 11, 47, 1'b0);
    #1 reset = 1'b0;
    #1;
    check_time("async_reset", 0, 0, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    seconds(59);
    check_time("post_reset_59", 0, 0, 1'b0);
    seconds(1);
    check_time("post_reset_60", 0, 1, 1'b1);

    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
